// File: rtl/board_pkg.sv
// Shared playfield description for the VGA draw stages: screen size, grid,
// frame geometry, palette and the small types used by the background renderer.
package board_pkg;

  // Screen and grid
  localparam int HOR_PIX      = 1024;
  localparam int VER_PIX      = 768;
  localparam int GRID_SIZE    = 16;

  // Outer frame in cells (border included) and border thickness in cells
  localparam int FRAME_X_SIZE = 40;
  localparam int FRAME_Y_SIZE = 20;
  localparam int FRAME_WIDTH  = 1;

  // Palette
  localparam logic [11:0] BORDER_COLOR = 12'h740;
  localparam logic [11:0] BG_COLOR     = 12'hda5;
  localparam logic [11:0] BG_ALT_COLOR = 12'hc94;
  localparam logic [11:0] FLASH_COLOR  = 12'hf00;

  // Border flash timing
  localparam int FLASH_FRAMES = 8;
  localparam int FLASH_COUNT  = 3;

  // Offset that centres a frame of 'cells' grid cells on an axis of 'pix' pixels
  function automatic int frame_offset(input int pix, input int cells, input int grid);
    return (pix - cells * grid) / 2;
  endfunction

  // Derived geometry for the other draw stages
  localparam int X_OUT = frame_offset(HOR_PIX, FRAME_X_SIZE, GRID_SIZE);
  localparam int Y_OUT = frame_offset(VER_PIX, FRAME_Y_SIZE, GRID_SIZE);
  localparam int X_IN  = X_OUT + FRAME_WIDTH * GRID_SIZE;
  localparam int Y_IN  = Y_OUT + FRAME_WIDTH * GRID_SIZE;

  // Border flash sequencer states
  typedef enum logic [1:0] {
    FLASH_IDLE = 2'd0,
    FLASH_ON   = 2'd1,
    FLASH_OFF  = 2'd2
  } flash_state_t;

  // One pixel's worth of timing signals, carried down the pipeline as a unit
  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
  } timing_t;

  // First pipeline stage: timing plus everything decoded from the pixel position
  typedef struct packed {
    timing_t     timing;
    logic [6:0]  cell_x;
    logic [5:0]  cell_y;
    logic        border_hit;
    logic        field_hit;
  } stage1_t;

endpackage

// File: rtl/bg_flash_fsm.sv
// Border flash sequencer: on a request it alternates ON and OFF phases of
// PHASE_FRAMES frames each, ON_PHASES times, then returns to idle.
// Outputs are registered and reflect the state the FSM is in.
module bg_flash_fsm
  import board_pkg::*;
#(
  parameter int PHASE_FRAMES = FLASH_FRAMES,
  parameter int ON_PHASES    = FLASH_COUNT
) (
  input  logic pclk,
  input  logic rst,
  input  logic frame_tick,
  input  logic flash_req,
  output logic flash_on,
  output logic flash_busy
);

  localparam int PH_W = (PHASE_FRAMES > 1) ? $clog2(PHASE_FRAMES) : 1;
  localparam int ON_W = $clog2(ON_PHASES + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASE_FRAMES - 1);
  localparam logic [ON_W-1:0] ON_LAST = ON_W'(ON_PHASES);

  flash_state_t    state_reg, state_next;
  logic [PH_W-1:0] ph_cnt_reg, ph_cnt_next;
  logic [ON_W-1:0] on_cnt_reg, on_cnt_next;
  logic            flash_on_reg, flash_on_next;
  logic            flash_busy_reg, flash_busy_next;

  // State, counters and the registered outputs
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg      <= FLASH_IDLE;
      ph_cnt_reg     <= '0;
      on_cnt_reg     <= '0;
      flash_on_reg   <= 1'b0;
      flash_busy_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ph_cnt_reg     <= ph_cnt_next;
      on_cnt_reg     <= on_cnt_next;
      flash_on_reg   <= flash_on_next;
      flash_busy_reg <= flash_busy_next;
    end
  end

  // Next state: requests only start from idle; phases advance on frame ticks
  always_comb begin
    state_next  = state_reg;
    ph_cnt_next = ph_cnt_reg;
    on_cnt_next = on_cnt_reg;
    unique case (state_reg)
      FLASH_IDLE: begin
        // A tick arriving with the request is not counted: the phase starts at 0
        if (flash_req) begin
          state_next  = FLASH_ON;
          ph_cnt_next = '0;
          on_cnt_next = ON_W'(1);
        end
      end
      FLASH_ON: begin
        if (frame_tick) begin
          if (ph_cnt_reg == PH_LAST) begin
            ph_cnt_next = '0;
            state_next  = FLASH_OFF;
          end else begin
            ph_cnt_next = ph_cnt_reg + PH_W'(1);
          end
        end
      end
      FLASH_OFF: begin
        if (frame_tick) begin
          if (ph_cnt_reg == PH_LAST) begin
            ph_cnt_next = '0;
            if (on_cnt_reg == ON_LAST) begin
              state_next  = FLASH_IDLE;
              on_cnt_next = '0;
            end else begin
              state_next  = FLASH_ON;
              on_cnt_next = on_cnt_reg + ON_W'(1);
            end
          end else begin
            ph_cnt_next = ph_cnt_reg + PH_W'(1);
          end
        end
      end
      default: begin
        state_next  = FLASH_IDLE;
        ph_cnt_next = '0;
        on_cnt_next = '0;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so the registers match the state register
  always_comb begin
    flash_on_next   = (state_next == FLASH_ON);
    flash_busy_next = (state_next != FLASH_IDLE);
  end

  assign flash_on   = flash_on_reg;
  assign flash_busy = flash_busy_reg;

endmodule

// File: rtl/draw_board_bg.sv
// Playfield background renderer. Two-stage pipeline directly behind the VGA
// timing generator: stage 1 decodes position (cell, border, field), stage 2
// picks the colour. Timing, colour and cell outputs all leave together.
module draw_board_bg #(
  parameter int          HOR_PIX      = board_pkg::HOR_PIX,
  parameter int          VER_PIX      = board_pkg::VER_PIX,
  parameter int          GRID_SIZE    = board_pkg::GRID_SIZE,
  parameter int          FRAME_X_SIZE = board_pkg::FRAME_X_SIZE,
  parameter int          FRAME_Y_SIZE = board_pkg::FRAME_Y_SIZE,
  parameter int          FRAME_WIDTH  = board_pkg::FRAME_WIDTH,
  parameter logic [11:0] BORDER_COLOR = board_pkg::BORDER_COLOR,
  parameter logic [11:0] BG_COLOR     = board_pkg::BG_COLOR,
  parameter logic [11:0] BG_ALT_COLOR = board_pkg::BG_ALT_COLOR,
  parameter logic [11:0] FLASH_COLOR  = board_pkg::FLASH_COLOR,
  parameter int          FLASH_FRAMES = board_pkg::FLASH_FRAMES,
  parameter int          FLASH_COUNT  = board_pkg::FLASH_COUNT
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic        checker_en,
  input  logic        flash_req,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [6:0]  cell_x,
  output logic [5:0]  cell_y,
  output logic        in_field,
  output logic        flash_busy
);

  import board_pkg::timing_t;
  import board_pkg::stage1_t;
  import board_pkg::frame_offset;

  // Geometry, all resolved at elaboration time
  localparam int SHIFT = $clog2(GRID_SIZE);
  localparam int X_OUT = frame_offset(HOR_PIX, FRAME_X_SIZE, GRID_SIZE);
  localparam int Y_OUT = frame_offset(VER_PIX, FRAME_Y_SIZE, GRID_SIZE);
  localparam int X_IN  = X_OUT + FRAME_WIDTH * GRID_SIZE;
  localparam int Y_IN  = Y_OUT + FRAME_WIDTH * GRID_SIZE;

  // Half-open ranges [lo, hi) on 11-bit unsigned counters
  localparam logic [10:0] OUT_X_LO = 11'(X_OUT);
  localparam logic [10:0] OUT_X_HI = 11'(HOR_PIX - X_OUT);
  localparam logic [10:0] OUT_Y_LO = 11'(Y_OUT);
  localparam logic [10:0] OUT_Y_HI = 11'(VER_PIX - Y_OUT);
  localparam logic [10:0] IN_X_LO  = 11'(X_IN);
  localparam logic [10:0] IN_X_HI  = 11'(HOR_PIX - X_IN);
  localparam logic [10:0] IN_Y_LO  = 11'(Y_IN);
  localparam logic [10:0] IN_Y_HI  = 11'(VER_PIX - Y_IN);

  timing_t     timing_in;
  stage1_t     s1_next, s1_reg;
  timing_t     s2_timing_reg;
  logic [6:0]  s2_cell_x_reg;
  logic [5:0]  s2_cell_y_reg;
  logic        s2_field_reg;
  logic [11:0] rgb_next, rgb_reg;
  logic        in_outer, in_inner;
  logic        vsync_prev_reg;
  logic        frame_tick_reg;
  logic        chk_act_reg;
  logic        flash_on;

  assign timing_in = '{
    hcount: hcount_in,
    hsync:  hsync_in,
    hblnk:  hblnk_in,
    vcount: vcount_in,
    vsync:  vsync_in,
    vblnk:  vblnk_in
  };

  // Position decode for the incoming pixel: outer frame box and inner field box
  always_comb begin
    in_outer = (hcount_in >= OUT_X_LO) && (hcount_in < OUT_X_HI) &&
               (vcount_in >= OUT_Y_LO) && (vcount_in < OUT_Y_HI);
    in_inner = (hcount_in >= IN_X_LO) && (hcount_in < IN_X_HI) &&
               (vcount_in >= IN_Y_LO) && (vcount_in < IN_Y_HI);
    s1_next            = '0;
    s1_next.timing     = timing_in;
    s1_next.cell_x     = 7'(hcount_in >> SHIFT);
    s1_next.cell_y     = 6'(vcount_in >> SHIFT);
    s1_next.border_hit = in_outer && !in_inner;
    s1_next.field_hit  = in_inner;
  end

  // Stage 1 register
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      s1_reg <= '0;
    end else begin
      s1_reg <= s1_next;
    end
  end

  // Colour choice: blanking, then border (flashing or not), then checker, then plain field
  always_comb begin
    rgb_next = 12'h000;
    if (s1_reg.timing.hblnk || s1_reg.timing.vblnk) begin
      rgb_next = 12'h000;
    end else if (s1_reg.border_hit) begin
      rgb_next = flash_on ? FLASH_COLOR : BORDER_COLOR;
    end else if (s1_reg.field_hit && chk_act_reg &&
                 (s1_reg.cell_x[0] ^ s1_reg.cell_y[0])) begin
      rgb_next = BG_ALT_COLOR;
    end else begin
      rgb_next = BG_COLOR;
    end
  end

  // Stage 2 register: colour plus everything that must stay aligned with it
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      s2_timing_reg <= '0;
      s2_cell_x_reg <= '0;
      s2_cell_y_reg <= '0;
      s2_field_reg  <= 1'b0;
      rgb_reg       <= '0;
    end else begin
      s2_timing_reg <= s1_reg.timing;
      s2_cell_x_reg <= s1_reg.cell_x;
      s2_cell_y_reg <= s1_reg.cell_y;
      s2_field_reg  <= s1_reg.field_hit;
      rgb_reg       <= rgb_next;
    end
  end

  // Frame boundary detect: one-cycle pulse after each rising edge of vsync
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_prev_reg <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      vsync_prev_reg <= vsync_in;
      frame_tick_reg <= vsync_in && !vsync_prev_reg;
    end
  end

  // Checker mode only changes between frames so a frame is never half-checkered
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      chk_act_reg <= 1'b0;
    end else if (frame_tick_reg) begin
      chk_act_reg <= checker_en;
    end
  end

  bg_flash_fsm #(
    .PHASE_FRAMES (FLASH_FRAMES),
    .ON_PHASES    (FLASH_COUNT)
  ) u_flash (
    .pclk       (pclk),
    .rst        (rst),
    .frame_tick (frame_tick_reg),
    .flash_req  (flash_req),
    .flash_on   (flash_on),
    .flash_busy (flash_busy)
  );

  assign hcount_out = s2_timing_reg.hcount;
  assign hsync_out  = s2_timing_reg.hsync;
  assign hblnk_out  = s2_timing_reg.hblnk;
  assign vcount_out = s2_timing_reg.vcount;
  assign vsync_out  = s2_timing_reg.vsync;
  assign vblnk_out  = s2_timing_reg.vblnk;
  assign rgb_out    = rgb_reg;
  assign cell_x     = s2_cell_x_reg;
  assign cell_y     = s2_cell_y_reg;
  assign in_field   = s2_field_reg;

endmodule

// File: tb/tb_draw_board_bg.sv
// Directed bench for draw_board_bg: a table of single pixels with hand-computed
// colours, plus sequences for checkerboard switching, border flash and reset.
module tb_draw_board_bg;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in;
  logic        hsync_in;
  logic        hblnk_in;
  logic [10:0] vcount_in;
  logic        vsync_in;
  logic        vblnk_in;
  logic        checker_en;
  logic        flash_req;
  logic [10:0] hcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  logic [10:0] vcount_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;
  logic [6:0]  cell_x;
  logic [5:0]  cell_y;
  logic        in_field;
  logic        flash_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          h;
    int          v;
    bit          hb;
    bit          vb;
    logic [11:0] rgb;
    bit          field;
  } vec_t;

  vec_t tbl [16];

  draw_board_bg dut (
    .pclk       (pclk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .vcount_in  (vcount_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .checker_en (checker_en),
    .flash_req  (flash_req),
    .hcount_out (hcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vcount_out (vcount_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out),
    .cell_x     (cell_x),
    .cell_y     (cell_y),
    .in_field   (in_field),
    .flash_busy (flash_busy)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive(input int h, input int v, input bit hb, input bit vb);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = (h % 2 == 1);
    vsync_in  = 1'b0;
  endtask

  // One pixel in, a blank filler behind it, then compare exactly two clocks later
  task automatic apply(input string tag, input int h, input int v, input bit hb, input bit vb,
                       input logic [11:0] rgb, input bit field);
    drive(h, v, hb, vb);
    step();
    drive(0, 0, 1'b1, 1'b1);
    step();
    $display("pix %s h=%0d v=%0d rgb=%03h cell=(%0d,%0d) field=%0b busy=%0b",
             tag, hcount_out, vcount_out, rgb_out, cell_x, cell_y, in_field, flash_busy);
    check({tag, "_rgb"},    rgb_out,    rgb);
    check({tag, "_hcount"}, hcount_out, h);
    check({tag, "_vcount"}, vcount_out, v);
    check({tag, "_hsync"},  hsync_out,  (h % 2 == 1));
    check({tag, "_hblnk"},  hblnk_out,  hb);
    check({tag, "_vblnk"},  vblnk_out,  vb);
    check({tag, "_vsync"},  vsync_out,  0);
    check({tag, "_cell_x"}, cell_x,     h / 16);
    check({tag, "_cell_y"}, cell_y,     v / 16);
    check({tag, "_field"},  in_field,   field);
  endtask

  // Short synthetic vertical sync; optionally raise flash_req in the tick cycle
  task automatic frame_pulse(input bit req_on_tick);
    drive(0, 780, 1'b1, 1'b1);
    vsync_in = 1'b1;
    step();
    if (req_on_tick) flash_req = 1'b1;
    step();
    flash_req = 1'b0;
    step();
    vsync_in = 1'b0;
    step();
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rgb"},    rgb_out,    0);
    check({tag, "_hcount"}, hcount_out, 0);
    check({tag, "_vcount"}, vcount_out, 0);
    check({tag, "_hsync"},  hsync_out,  0);
    check({tag, "_hblnk"},  hblnk_out,  0);
    check({tag, "_vsync"},  vsync_out,  0);
    check({tag, "_vblnk"},  vblnk_out,  0);
    check({tag, "_cell_x"}, cell_x,     0);
    check({tag, "_cell_y"}, cell_y,     0);
    check({tag, "_field"},  in_field,   0);
    check({tag, "_busy"},   flash_busy, 0);
  endtask

  // Full flash run: 48 frames, ON in frames 0-7, 16-23, 32-39 counted from the request
  task automatic run_flash(input string tag, input bit coincident, input int extra_a, input int extra_b);
    if (coincident) begin
      frame_pulse(1'b1);
    end else begin
      drive(300, 300, 1'b0, 1'b0);
      flash_req = 1'b1;
      step();
      flash_req = 1'b0;
    end
    check({tag, "_busy_start"}, flash_busy, 1);
    for (int k = 0; k < 48; k++) begin
      if (k == extra_a || k == extra_b) begin
        drive(300, 300, 1'b0, 1'b0);
        flash_req = 1'b1;
        step();
        flash_req = 1'b0;
      end
      apply($sformatf("%s_f%0d", tag, k), 192, 224, 1'b0, 1'b0,
            ((k / 8) % 2 == 0) ? 12'hf00 : 12'h740, 1'b0);
      check($sformatf("%s_f%0d_busy", tag, k), flash_busy, 1);
      frame_pulse(1'b0);
    end
    check({tag, "_busy_end"}, flash_busy, 0);
    apply({tag, "_after"}, 192, 224, 1'b0, 1'b0, 12'h740, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // h, v, hblnk, vblnk, rgb, in_field
    tbl[0]  = '{192, 224, 1'b0, 1'b0, 12'h740, 1'b0};
    tbl[1]  = '{207, 400, 1'b0, 1'b0, 12'h740, 1'b0};
    tbl[2]  = '{816, 300, 1'b0, 1'b0, 12'h740, 1'b0};
    tbl[3]  = '{500, 543, 1'b0, 1'b0, 12'h740, 1'b0};
    tbl[4]  = '{500, 544, 1'b0, 1'b0, 12'hda5, 1'b0};
    tbl[5]  = '{0,   0,   1'b0, 1'b0, 12'hda5, 1'b0};
    tbl[6]  = '{208, 240, 1'b0, 1'b0, 12'hda5, 1'b1};
    tbl[7]  = '{815, 527, 1'b0, 1'b0, 12'hda5, 1'b1};
    tbl[8]  = '{191, 300, 1'b0, 1'b0, 12'hda5, 1'b0};
    tbl[9]  = '{831, 543, 1'b0, 1'b0, 12'h740, 1'b0};
    tbl[10] = '{832, 300, 1'b0, 1'b0, 12'hda5, 1'b0};
    tbl[11] = '{1023, 767, 1'b0, 1'b0, 12'hda5, 1'b0};
    tbl[12] = '{100, 400, 1'b1, 1'b0, 12'h000, 1'b0};
    tbl[13] = '{192, 224, 1'b0, 1'b1, 12'h000, 1'b0};
    tbl[14] = '{816, 527, 1'b0, 1'b0, 12'h740, 1'b0};
    tbl[15] = '{815, 239, 1'b0, 1'b0, 12'h740, 1'b0};

    // Reset held with live-looking inputs: every output stays 0
    rst        = 1'b1;
    checker_en = 1'b0;
    flash_req  = 1'b0;
    drive(300, 300, 1'b1, 1'b1);
    hsync_in = 1'b1;
    step();
    step();
    step();
    check_all_zero("in_reset");

    // Release: first pixel comes out exactly two clocks later
    rst = 1'b0;
    apply("origin", 0, 0, 1'b0, 1'b0, 12'hda5, 1'b0);

    // Geometry table, checker off, no flash
    for (int i = 0; i < 16; i++) begin
      apply($sformatf("vec%0d", i), tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb,
            tbl[i].rgb, tbl[i].field);
    end

    // Checker requested mid-frame: this frame stays plain
    checker_en = 1'b1;
    apply("chk_same_frame", 224, 240, 1'b0, 1'b0, 12'hda5, 1'b1);
    frame_pulse(1'b0);
    apply("chk_13_15",  208, 240, 1'b0, 1'b0, 12'hda5, 1'b1);
    apply("chk_14_15",  224, 240, 1'b0, 1'b0, 12'hc94, 1'b1);
    apply("chk_outside", 100, 100, 1'b0, 1'b0, 12'hda5, 1'b0);
    apply("chk_14_16",  224, 256, 1'b0, 1'b0, 12'hda5, 1'b1);
    apply("chk_15_16",  240, 256, 1'b0, 1'b0, 12'hc94, 1'b1);
    apply("chk_border", 207, 256, 1'b0, 1'b0, 12'h740, 1'b0);
    // Dropping the request also waits for the frame boundary
    checker_en = 1'b0;
    apply("chk_off_same_frame", 224, 240, 1'b0, 1'b0, 12'hc94, 1'b1);
    frame_pulse(1'b0);
    apply("chk_off", 224, 240, 1'b0, 1'b0, 12'hda5, 1'b1);

    // Flash with extra requests in an ON and an OFF phase; both ignored
    run_flash("flash_a", 1'b0, 5, 12);
    // Flash requested in the same cycle as a frame tick, extra request late on
    run_flash("flash_b", 1'b1, 40, -1);

    // Reset in the middle of a flash and of a line
    drive(300, 300, 1'b0, 1'b0);
    flash_req = 1'b1;
    step();
    flash_req = 1'b0;
    frame_pulse(1'b0);
    frame_pulse(1'b0);
    check("mid_flash_busy", flash_busy, 1);
    drive(192, 224, 1'b0, 1'b0);
    step();
    drive(400, 300, 1'b0, 1'b0);
    step();
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    step();
    rst = 1'b0;
    apply("after_rst", 192, 224, 1'b0, 1'b0, 12'h740, 1'b0);
    check("after_rst_busy", flash_busy, 0);
    frame_pulse(1'b0);
    apply("after_rst_frame", 192, 224, 1'b0, 1'b0, 12'h740, 1'b0);
    check("after_rst_frame_busy", flash_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
